// File: rtl/bp_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// bp_cfg_loader_pkg
//
// Shared config-link definitions used by the boot-time config loader.
//   - Config register address map (tile-local register offsets).
//   - Loader FSM state encoding.
//   - Single-beat config write record {addr, data}.
//   - Helpers that map a loader state to the write it issues.
// -----------------------------------------------------------------------------
package bp_cfg_loader_pkg;

    // Config-link register map
    localparam logic [15:0] cfg_addr_clk_osc_gp     = 16'h0000;
    localparam logic [15:0] cfg_addr_reset_gp       = 16'h0001;
    localparam logic [15:0] cfg_addr_freeze_gp      = 16'h0002;
    localparam logic [15:0] cfg_addr_start_pc_lo_gp = 16'h0040;
    localparam logic [15:0] cfg_addr_start_pc_hi_gp = 16'h0041;
    localparam logic [15:0] cfg_addr_cce_mode_gp    = 16'h0060;
    localparam logic [15:0] cfg_addr_ucode_base_gp  = 16'h8000;

    // Base of the config space in the global address map
    localparam logic [31:0] cfg_base_addr_gp        = 32'h0100_0000;

    typedef enum logic [3:0] {
        e_cfg_idle,
        e_cfg_freeze,
        e_cfg_rst_hi,
        e_cfg_rst_lo,
        e_cfg_pc_lo,
        e_cfg_pc_hi,
        e_cfg_mode,
        e_cfg_uc_fetch,
        e_cfg_uc_send,
        e_cfg_unfreeze,
        e_cfg_done
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } bp_cfg_write_s;

    // True for every state that presents a write on the config link
    function automatic logic cfg_state_is_write(input bp_cfg_loader_state_e state);
        return state inside {e_cfg_freeze, e_cfg_rst_hi, e_cfg_rst_lo, e_cfg_pc_lo,
                             e_cfg_pc_hi, e_cfg_mode, e_cfg_uc_send, e_cfg_unfreeze};
    endfunction

    // Fixed address/data for each write state. For the ucode window only the
    // address is meaningful here; the data comes from the ROM capture path.
    function automatic bp_cfg_write_s cfg_write_for(
        input bp_cfg_loader_state_e state,
        input logic [11:0]          ucode_idx,
        input logic [63:0]          start_pc,
        input logic [31:0]          cce_mode
    );
        bp_cfg_write_s wr;
        wr.addr = 16'h0000;
        wr.data = 32'h0000_0000;
        case (state)
            e_cfg_freeze: begin
                wr.addr = cfg_addr_freeze_gp;
                wr.data = 32'd1;
            end
            e_cfg_rst_hi: begin
                wr.addr = cfg_addr_reset_gp;
                wr.data = 32'd1;
            end
            e_cfg_rst_lo: begin
                wr.addr = cfg_addr_reset_gp;
                wr.data = 32'd0;
            end
            e_cfg_pc_lo: begin
                wr.addr = cfg_addr_start_pc_lo_gp;
                wr.data = start_pc[31:0];
            end
            e_cfg_pc_hi: begin
                wr.addr = cfg_addr_start_pc_hi_gp;
                wr.data = start_pc[63:32];
            end
            e_cfg_mode: begin
                wr.addr = cfg_addr_cce_mode_gp;
                wr.data = cce_mode;
            end
            e_cfg_uc_send: begin
                wr.addr = cfg_addr_ucode_base_gp | {4'h0, ucode_idx};
            end
            e_cfg_unfreeze: begin
                wr.addr = cfg_addr_freeze_gp;
                wr.data = 32'd0;
            end
            default: begin
                wr.addr = 16'h0000;
                wr.data = 32'h0000_0000;
            end
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/bp_cfg_loader.sv
// -----------------------------------------------------------------------------
// bp_cfg_loader
//
// Boot-time sequencer driving the config link with single-beat register
// writes: freeze tile, pulse reset, program start PC and CCE mode, stream CCE
// microcode from a synchronous ROM into the ucode window, then unfreeze.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               begin a boot sequence (honoured in IDLE/DONE only)
//   start_pc_i            64-bit boot PC, sampled on the accepted start
//   cce_mode_i            CCE mode word, sampled on the accepted start
//   cfg_v_o/addr_o/data_o config write; accepted when cfg_v_o & cfg_ready_i
//   cfg_ready_i           config link ready
//   ucode_r_v_o/addr_o    ROM read strobe and word address
//   ucode_data_i          ROM data, valid one cycle after ucode_r_v_o
//   busy_o                sequence in progress
//   done_o                level, set on final write, cleared by next start
// -----------------------------------------------------------------------------
module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter int cfg_addr_width_p   = 16,
    parameter int cfg_data_width_p   = 32,
    parameter int ucode_els_p        = 256,
    parameter int ucode_addr_width_p = 12
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          start_i,
    input  logic [63:0]                   start_pc_i,
    input  logic [31:0]                   cce_mode_i,

    output logic                          cfg_v_o,
    output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
    output logic [cfg_data_width_p-1:0]   cfg_data_o,
    input  logic                          cfg_ready_i,

    output logic                          ucode_r_v_o,
    output logic [ucode_addr_width_p-1:0] ucode_addr_o,
    input  logic [cfg_data_width_p-1:0]   ucode_data_i,

    output logic                          busy_o,
    output logic                          done_o
);

    // Guard the zero-length case so the last-index constant stays in range
    localparam int ucode_last_lp = (ucode_els_p > 0) ? ucode_els_p - 1 : 0;
    localparam logic [ucode_addr_width_p-1:0] ucode_last_idx_lp =
        ucode_addr_width_p'(ucode_last_lp);

    bp_cfg_loader_state_e          state_r, state_n;
    logic [ucode_addr_width_p-1:0] counter_r, counter_n;
    logic [63:0]                   start_pc_r;
    logic [31:0]                   cce_mode_r;
    logic [cfg_data_width_p-1:0]   data_r;
    logic                          uc_first_r;
    logic                          fire;
    logic                          start_accept;
    bp_cfg_write_s                 wr_n;

    always_comb begin
        fire         = cfg_v_o & cfg_ready_i;
        start_accept = start_i & ((state_r == e_cfg_idle) || (state_r == e_cfg_done));
        state_n      = state_r;
        counter_n    = counter_r;

        case (state_r)
            e_cfg_idle, e_cfg_done: if (start_accept) state_n = e_cfg_freeze;
            e_cfg_freeze:           if (fire) state_n = e_cfg_rst_hi;
            e_cfg_rst_hi:           if (fire) state_n = e_cfg_rst_lo;
            e_cfg_rst_lo:           if (fire) state_n = e_cfg_pc_lo;
            e_cfg_pc_lo:            if (fire) state_n = e_cfg_pc_hi;
            e_cfg_pc_hi:            if (fire) state_n = e_cfg_mode;
            e_cfg_mode: begin
                if (fire) state_n = (ucode_els_p > 0) ? e_cfg_uc_fetch : e_cfg_unfreeze;
            end
            e_cfg_uc_fetch:         state_n = e_cfg_uc_send;
            e_cfg_uc_send: begin
                if (fire) begin
                    if (counter_r == ucode_last_idx_lp) begin
                        state_n   = e_cfg_unfreeze;
                        counter_n = '0;
                    end else begin
                        state_n   = e_cfg_uc_fetch;
                        counter_n = counter_r + ucode_addr_width_p'(1);
                    end
                end
            end
            e_cfg_unfreeze:         if (fire) state_n = e_cfg_done;
            default:                state_n = e_cfg_idle;
        endcase

        // The write for the state being entered is precomputed so the
        // address/valid outputs can be registered.
        wr_n = cfg_write_for(state_n, 12'(counter_n), start_pc_r, cce_mode_r);
    end

    // Control state and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_cfg_idle;
            counter_r    <= '0;
            cfg_v_o      <= 1'b0;
            cfg_addr_o   <= '0;
            ucode_r_v_o  <= 1'b0;
            ucode_addr_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            uc_first_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            counter_r    <= counter_n;
            cfg_v_o      <= cfg_state_is_write(state_n);
            cfg_addr_o   <= cfg_addr_width_p'(wr_n.addr);
            ucode_r_v_o  <= (state_n == e_cfg_uc_fetch);
            ucode_addr_o <= (state_n == e_cfg_uc_fetch) ? counter_n : '0;
            busy_o       <= !((state_n == e_cfg_idle) || (state_n == e_cfg_done));
            done_o       <= (state_n == e_cfg_done);
            // High only on the first UC_SEND cycle, when the ROM word is live
            uc_first_r   <= (state_r == e_cfg_uc_fetch);
        end
    end

    // Data holding registers; output gating keeps them invisible after reset
    always_ff @(posedge clk_i) begin
        if (start_accept) begin
            start_pc_r <= start_pc_i;
            cce_mode_r <= cce_mode_i;
        end
        if (state_n == e_cfg_uc_send) begin
            // Capture the ROM word on the entry cycle; hold it while stalled
            if (uc_first_r) data_r <= ucode_data_i;
        end else begin
            data_r <= cfg_data_width_p'(wr_n.data);
        end
    end

    // On the UC_SEND entry cycle the ROM word bypasses the holding register
    // so a write can complete in that same cycle.
    always_comb begin
        cfg_data_o = '0;
        if (cfg_v_o) cfg_data_o = uc_first_r ? ucode_data_i : data_r;
    end

endmodule

// File: tb/tb_bp_cfg_loader.sv
module tb_bp_cfg_loader;
    import bp_cfg_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset, start, start_z;
    logic [63:0] start_pc;
    logic [31:0] cce_mode;

    logic        cfg_v, cfg_ready, ucode_r_v, busy, done;
    logic [15:0] cfg_addr;
    logic [31:0] cfg_data, ucode_data;
    logic [11:0] ucode_addr;

    logic        cfg_v_z, cfg_ready_z, ucode_r_v_z, busy_z, done_z;
    logic [15:0] cfg_addr_z;
    logic [31:0] cfg_data_z, ucode_data_z;
    logic [11:0] ucode_addr_z;

    bp_cfg_loader #(.ucode_els_p(4)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .start_pc_i(start_pc),
        .cce_mode_i(cce_mode), .cfg_v_o(cfg_v), .cfg_addr_o(cfg_addr),
        .cfg_data_o(cfg_data), .cfg_ready_i(cfg_ready), .ucode_r_v_o(ucode_r_v),
        .ucode_addr_o(ucode_addr), .ucode_data_i(ucode_data), .busy_o(busy),
        .done_o(done)
    );

    bp_cfg_loader #(.ucode_els_p(0)) dut_z (
        .clk_i(clk), .reset_i(reset), .start_i(start_z), .start_pc_i(start_pc),
        .cce_mode_i(cce_mode), .cfg_v_o(cfg_v_z), .cfg_addr_o(cfg_addr_z),
        .cfg_data_o(cfg_data_z), .cfg_ready_i(cfg_ready_z), .ucode_r_v_o(ucode_r_v_z),
        .ucode_addr_o(ucode_addr_z), .ucode_data_i(ucode_data_z), .busy_o(busy_z),
        .done_o(done_z)
    );

    // Synchronous ROM: word i = C0DE_1000 + i, garbage except the cycle after a read
    logic        rom_vld = 1'b0;
    logic [31:0] rom_q   = 32'h0;
    always @(posedge clk) begin
        rom_vld <= ucode_r_v;
        rom_q   <= 32'hC0DE_1000 + 32'(ucode_addr);
    end
    assign ucode_data   = rom_vld ? rom_q : 32'hBAD0_BAD0;
    assign ucode_data_z = 32'hBAD0_BAD0;

    bp_cfg_write_s exp_q[$];
    bp_cfg_write_s exp_qz[$];
    int checks = 0;
    int errors = 0;

    // Backpressure plan: hold ready low for st_len[k] cycles on write st_addr[k]
    logic [15:0] st_addr [2];
    int          st_len  [2];
    int          st_cnt  [2];
    int          epoch = 0;
    int          seen_epoch = -1;
    logic        rdy;
    logic        z_rom_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_stalls(input logic [15:0] a0, input int l0,
                              input logic [15:0] a1, input int l1);
        st_addr[0] = a0; st_len[0] = l0;
        st_addr[1] = a1; st_len[1] = l1;
        epoch++;
    endtask

    task automatic push_seq(input logic [63:0] pc, input logic [31:0] mode);
        exp_q.push_back(bp_cfg_write_s'({16'h0002, 32'd1}));
        exp_q.push_back(bp_cfg_write_s'({16'h0001, 32'd1}));
        exp_q.push_back(bp_cfg_write_s'({16'h0001, 32'd0}));
        exp_q.push_back(bp_cfg_write_s'({16'h0040, pc[31:0]}));
        exp_q.push_back(bp_cfg_write_s'({16'h0041, pc[63:32]}));
        exp_q.push_back(bp_cfg_write_s'({16'h0060, mode}));
        exp_q.push_back(bp_cfg_write_s'({16'h8000, 32'hC0DE_1000}));
        exp_q.push_back(bp_cfg_write_s'({16'h8001, 32'hC0DE_1001}));
        exp_q.push_back(bp_cfg_write_s'({16'h8002, 32'hC0DE_1002}));
        exp_q.push_back(bp_cfg_write_s'({16'h8003, 32'hC0DE_1003}));
        exp_q.push_back(bp_cfg_write_s'({16'h0002, 32'd0}));
    endtask

    task automatic start_and_wait(input logic [63:0] pc, input logic [31:0] mode,
                                  input int exp_lat, input string name);
        int t0;
        bit got;
        start_pc = pc; cce_mode = mode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_pc = 64'hDEAD_BEEF_DEAD_BEEF;
        cce_mode = 32'hFFFF_FFFF;
        t0 = cyc;
        check({name, "_done_cleared"}, 64'(done), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout done never rose, required within 200 cycles", name);
        end else begin
            check({name, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
            check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    // Monitor + ready responder for the 4-word instance
    initial begin
        cfg_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                st_cnt[0] = 0;
                st_cnt[1] = 0;
            end
            rdy = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (rdy && cfg_v && cfg_addr == st_addr[k] && st_cnt[k] < st_len[k]) begin
                    rdy = 1'b0;
                    st_cnt[k]++;
                end
            end
            cfg_ready = rdy;
            if (!reset && cfg_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write got addr=%h data=%h, no write expected", cfg_addr, cfg_data);
                end else begin
                    if (cfg_addr !== exp_q[0].addr || cfg_data !== exp_q[0].data) begin
                        errors++;
                        $display("FAIL write_%s got addr=%h data=%h expected addr=%h data=%h",
                                 rdy ? "accept" : "stall", cfg_addr, cfg_data, exp_q[0].addr, exp_q[0].data);
                    end
                    if (rdy) void'(exp_q.pop_front());
                end
            end
            if (!reset && cfg_v && ucode_r_v) begin
                checks++; errors++;
                $display("FAIL rom_read_with_write got both 1, expected exclusive");
            end
        end
    end

    // Monitor for the zero-ucode instance (ready tied high)
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && cfg_v_z) begin
                checks++;
                if (exp_qz.size() == 0) begin
                    errors++;
                    $display("FAIL z_extra_write got addr=%h data=%h, no write expected", cfg_addr_z, cfg_data_z);
                end else begin
                    if (cfg_addr_z !== exp_qz[0].addr || cfg_data_z !== exp_qz[0].data) begin
                        errors++;
                        $display("FAIL z_write got addr=%h data=%h expected addr=%h data=%h",
                                 cfg_addr_z, cfg_data_z, exp_qz[0].addr, exp_qz[0].data);
                    end
                    void'(exp_qz.pop_front());
                end
            end
            if (ucode_r_v_z) z_rom_seen = 1'b1;
        end
    end

    initial begin
        int  t0;
        bit  got;
        reset = 1'b1; start = 1'b0; start_z = 1'b0;
        start_pc = 64'h0; cce_mode = 32'h0; cfg_ready_z = 1'b1;
        set_stalls(16'hFFFF, 0, 16'hFFFF, 0);
        repeat (3) @(negedge clk);

        check("rst_cfg_v",      64'(cfg_v),        64'd0);
        check("rst_cfg_addr",   64'(cfg_addr),     64'd0);
        check("rst_cfg_data",   64'(cfg_data),     64'd0);
        check("rst_ucode_r_v",  64'(ucode_r_v),    64'd0);
        check("rst_ucode_addr", 64'(ucode_addr),   64'd0);
        check("rst_busy",       64'(busy),         64'd0);
        check("rst_done",       64'(done),         64'd0);
        check("rst_z_cfg_v",    64'(cfg_v_z),      64'd0);
        check("rst_z_busy",     64'(busy_z),       64'd0);
        check("rst_z_done",     64'(done_z),       64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal run
        push_seq(64'h0000_0000_8000_0000, 32'd1);
        start_and_wait(64'h0000_0000_8000_0000, 32'd1, 15, "nominal");

        // Restart from DONE with a wide PC; a start pulse during MODE is ignored
        push_seq(64'h0000_0001_2345_6780, 32'h0000_00A5);
        fork
            start_and_wait(64'h0000_0001_2345_6780, 32'h0000_00A5, 15, "restart");
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (cfg_v && cfg_addr == 16'h0060) break;
                end
                start = 1'b1;
                start_pc = 64'hFFFF_0000_FFFF_0000;
                @(negedge clk);
                start = 1'b0;
            end
        join

        // Backpressure on PC_HI and the 2nd ucode word
        set_stalls(16'h0041, 3, 16'h8001, 3);
        push_seq(64'h0000_0000_8000_0000, 32'd1);
        start_and_wait(64'h0000_0000_8000_0000, 32'd1, 21, "backpressure");

        // ROM word must be held internally across a long stall
        set_stalls(16'h8002, 5, 16'hFFFF, 0);
        push_seq(64'h0000_0000_8000_0000, 32'd1);
        start_and_wait(64'h0000_0000_8000_0000, 32'd1, 20, "rom_hold");

        // Reset during the 3rd ucode word, then replay
        set_stalls(16'h8002, 5, 16'hFFFF, 0);
        push_seq(64'h0000_0000_8000_0000, 32'd1);
        start_pc = 64'h0000_0000_8000_0000; cce_mode = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_v && cfg_addr == 16'h8002) begin got = 1'b1; break; end
        end
        check("midrst_reached_word2", 64'(got), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cfg_v",     64'(cfg_v),     64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_done",      64'(done),      64'd0);
        check("midrst_ucode_r_v", 64'(ucode_r_v), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        set_stalls(16'hFFFF, 0, 16'hFFFF, 0);
        push_seq(64'h0000_0000_8000_0000, 32'd1);
        start_and_wait(64'h0000_0000_8000_0000, 32'd1, 15, "replay");

        // Zero-length ucode instance
        exp_qz.push_back(bp_cfg_write_s'({16'h0002, 32'd1}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0001, 32'd1}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0001, 32'd0}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0040, 32'h0000_1000}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0041, 32'h0000_0000}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0060, 32'h0000_0003}));
        exp_qz.push_back(bp_cfg_write_s'({16'h0002, 32'd0}));
        start_pc = 64'h0000_0000_0000_1000; cce_mode = 32'h3; start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        start_pc = 64'hDEAD_BEEF_DEAD_BEEF;
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_z) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL zero_timeout done never rose, required within 100 cycles");
        end else begin
            check("zero_latency", 64'(cyc - t0), 64'd7);
        end
        check("zero_writes_left", 64'(exp_qz.size()), 64'd0);
        check("zero_rom_read",    64'(z_rom_seen),    64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
